// File: rtl/core_alu_rv32i_pkg.sv
// Shared constants and types for the RV32I execute unit.
// Holds XLEN, shift-amount width and the shifter control bundle.
package core_alu_rv32i_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef struct packed {
    logic [SHAMT_W-1:0] shamt;
    logic               right;
    logic               arith;
  } shift_ctl_t;

endpackage

// File: rtl/core_alu_shifter.sv
// Barrel shifter shared by all six RV32I shift ops.
// Ports: operand, shamt, right (direction), arith (sign fill) -> value.
module core_alu_shifter
  import core_alu_rv32i_pkg::*;
(
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               right,
  input  logic               arith,
  output logic [XLEN-1:0]    value
);

  always_comb begin
    value = '0;
    if (!right)
      value = operand << shamt;
    else if (arith)
      value = $unsigned($signed(operand) >>> shamt);
    else
      value = operand >> shamt;
  end

endmodule

// File: rtl/core_alu_rv32i.sv
// RV32I execute unit: ALU ops, branch compare, load/store address.
// Ports: rst_n, clk, op strobes, rs1, rs2, imm -> registered result.
module core_alu_rv32i
  import core_alu_rv32i_pkg::*;
(
  input  logic            rst_n,
  input  logic            clk,
  input  logic            i_addi,
  input  logic            i_slti,
  input  logic            i_sltiu,
  input  logic            i_xori,
  input  logic            i_ori,
  input  logic            i_andi,
  input  logic            i_slli,
  input  logic            i_srli,
  input  logic            i_srai,
  input  logic            i_add,
  input  logic            i_sub,
  input  logic            i_sll,
  input  logic            i_slt,
  input  logic            i_sltu,
  input  logic            i_xor,
  input  logic            i_srl,
  input  logic            i_sra,
  input  logic            i_or,
  input  logic            i_and,
  input  logic            i_beq,
  input  logic            i_bne,
  input  logic            i_blt,
  input  logic            i_bge,
  input  logic            i_bltu,
  input  logic            i_bgeu,
  input  logic            i_lb,
  input  logic            i_lh,
  input  logic            i_lw,
  input  logic            i_lbu,
  input  logic            i_lhu,
  input  logic            i_sb,
  input  logic            i_sh,
  input  logic            i_sw,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sum_imm;
  logic [XLEN-1:0] sum_reg;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] cmp_b;
  logic [XLEN-1:0] shf;
  logic [XLEN-1:0] nxt;
  logic            use_rs2;
  logic            lt_s;
  logic            lt_u;
  logic            eq;
  logic            any_br;
  logic            any_mem;
  shift_ctl_t      sctl;

  assign sum_imm = rs1 + imm;
  assign sum_reg = rs1 + rs2;
  assign diff    = rs1 - rs2;

  assign any_br  = i_beq | i_bne | i_blt
                 | i_bge | i_bltu | i_bgeu;
  assign any_mem = i_lb | i_lh | i_lw | i_lbu
                 | i_lhu | i_sb | i_sh | i_sw;

  // Compare operand b: every compare that outranks SLTI/SLTIU uses rs2.
  assign use_rs2 = i_slt | i_sltu | any_br;
  assign cmp_b   = use_rs2 ? rs2 : imm;
  assign lt_s    = $signed(rs1) < $signed(cmp_b);
  assign lt_u    = rs1 < cmp_b;
  assign eq      = rs1 == rs2;

  // Shifter control follows the same last-wins priority as the result.
  always_comb begin
    sctl.shamt = imm[SHAMT_W-1:0] | rs2[SHAMT_W-1:0];
    sctl.right = 1'b0;
    sctl.arith = 1'b0;
    if (i_srli) begin
      sctl.right = 1'b1;
      sctl.arith = 1'b0;
    end
    if (i_srai) begin
      sctl.right = 1'b1;
      sctl.arith = 1'b1;
    end
    if (i_sll | i_srl | i_sra) begin
      sctl.shamt = rs2[SHAMT_W-1:0];
      sctl.right = 1'b0;
      sctl.arith = 1'b0;
    end
    if (i_srl) begin
      sctl.right = 1'b1;
      sctl.arith = 1'b0;
    end
    if (i_sra) begin
      sctl.right = 1'b1;
      sctl.arith = 1'b1;
    end
  end

  core_alu_shifter u_shifter (
    .operand (rs1),
    .shamt   (sctl.shamt),
    .right   (sctl.right),
    .arith   (sctl.arith),
    .value   (shf)
  );

  // Later strobes in port order override earlier ones.
  always_comb begin
    nxt = '0;
    if (i_addi)  nxt = sum_imm;
    if (i_slti)  nxt = {31'b0, lt_s};
    if (i_sltiu) nxt = {31'b0, lt_u};
    if (i_xori)  nxt = rs1 ^ imm;
    if (i_ori)   nxt = rs1 | imm;
    if (i_andi)  nxt = rs1 & imm;
    if (i_slli)  nxt = shf;
    if (i_srli)  nxt = shf;
    if (i_srai)  nxt = shf;
    if (i_add)   nxt = sum_reg;
    if (i_sub)   nxt = diff;
    if (i_sll)   nxt = shf;
    if (i_slt)   nxt = {31'b0, lt_s};
    if (i_sltu)  nxt = {31'b0, lt_u};
    if (i_xor)   nxt = rs1 ^ rs2;
    if (i_srl)   nxt = shf;
    if (i_sra)   nxt = shf;
    if (i_or)    nxt = rs1 | rs2;
    if (i_and)   nxt = rs1 & rs2;
    if (i_beq)   nxt = {31'b0, eq};
    if (i_bne)   nxt = {31'b0, !eq};
    if (i_blt)   nxt = {31'b0, lt_s};
    if (i_bge)   nxt = {31'b0, !lt_s};
    if (i_bltu)  nxt = {31'b0, lt_u};
    if (i_bgeu)  nxt = {31'b0, !lt_u};
    if (any_mem) nxt = sum_imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      result <= '0;
    else
      result <= nxt;
  end

endmodule

// File: tb/tb_core_alu_rv32i.sv
// Scoreboard bench for core_alu_rv32i with directed vectors.
// Driver queues expected values; a monitor checks each cycle.
module tb_core_alu_rv32i;

  localparam int ADDI = 0,  SLTI = 1,  SLTIU = 2, XORI = 3;
  localparam int ORI  = 4,  ANDI = 5,  SLLI = 6,  SRLI = 7;
  localparam int SRAI = 8,  ADD  = 9,  SUB  = 10, SLL  = 11;
  localparam int SLT  = 12, SLTU = 13, XOR  = 14, SRL  = 15;
  localparam int SRA  = 16, OR   = 17, AND  = 18, BEQ  = 19;
  localparam int BNE  = 20, BLT  = 21, BGE  = 22, BLTU = 23;
  localparam int BGEU = 24, LB   = 25, LH   = 26, LW   = 27;
  localparam int LBU  = 28, LHU  = 29, SB   = 30, SH   = 31;
  localparam int SW   = 32;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [32:0] st;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] imm;
  logic [31:0] result;

  exp_t q[$];
  int   checks;
  int   failures;

  core_alu_rv32i dut (
    .rst_n   (rst_n),
    .clk     (clk),
    .i_addi  (st[ADDI]),
    .i_slti  (st[SLTI]),
    .i_sltiu (st[SLTIU]),
    .i_xori  (st[XORI]),
    .i_ori   (st[ORI]),
    .i_andi  (st[ANDI]),
    .i_slli  (st[SLLI]),
    .i_srli  (st[SRLI]),
    .i_srai  (st[SRAI]),
    .i_add   (st[ADD]),
    .i_sub   (st[SUB]),
    .i_sll   (st[SLL]),
    .i_slt   (st[SLT]),
    .i_sltu  (st[SLTU]),
    .i_xor   (st[XOR]),
    .i_srl   (st[SRL]),
    .i_sra   (st[SRA]),
    .i_or    (st[OR]),
    .i_and   (st[AND]),
    .i_beq   (st[BEQ]),
    .i_bne   (st[BNE]),
    .i_blt   (st[BLT]),
    .i_bge   (st[BGE]),
    .i_bltu  (st[BLTU]),
    .i_bgeu  (st[BGEU]),
    .i_lb    (st[LB]),
    .i_lh    (st[LH]),
    .i_lw    (st[LW]),
    .i_lbu   (st[LBU]),
    .i_lhu   (st[LHU]),
    .i_sb    (st[SB]),
    .i_sh    (st[SH]),
    .i_sw    (st[SW]),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .result  (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] b(input int k);
    logic [32:0] one;
    one = 33'd1;
    return one << k;
  endfunction

  task automatic check(input string n,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", n, got, exp);
    end
  endtask

  task automatic drive(input logic [32:0] s,
                       input logic [31:0] a,
                       input logic [31:0] c,
                       input logic [31:0] i,
                       input logic [31:0] e,
                       input string n);
    exp_t x;
    @(negedge clk);
    st  = s;
    rs1 = a;
    rs2 = c;
    imm = i;
    x.exp  = e;
    x.name = n;
    q.push_back(x);
  endtask

  // Monitor: one registered result per edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        x = q.pop_front();
        check(x.name, result, x.exp);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    st  = '0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;
    #1;
    check("reset_state", result, 32'h0);
    #11;
    rst_n = 1'b1;

    drive(b(ADDI), 32'h000000F0, 0, 32'h0000000F,
          32'h000000FF, "addi");
    drive(b(SLTI), 32'h86C160F0, 0, 32'h70F0680F,
          32'h1, "slti");
    drive(b(SLTIU), 32'h86C160F0, 0, 32'h70F0680F,
          32'h0, "sltiu");
    drive(b(SLT), 32'h86C160F0, 32'h70F0680F, 0,
          32'h1, "slt");
    drive(b(SLTU), 32'h86C160F0, 32'h70F0680F, 0,
          32'h0, "sltu");
    drive(b(XORI), 32'h0854AA35, 0, 32'h0557D0BE,
          32'h0D037A8B, "xori");
    drive(b(XORI) | b(ORI), 32'h0854AA35, 0,
          32'h0557D0BE, 32'h0D57FABF, "ori_acc");
    drive(b(XORI) | b(ORI) | b(ANDI), 32'h0854AA35, 0,
          32'h0557D0BE, 32'h00548034, "andi_acc");
    drive(b(SLLI), 32'h0E5460F5, 0, 32'h4,
          32'hE5460F50, "slli");
    drive(b(SRLI), 32'h8E5460F5, 32'h4, 0,
          32'h08E5460F, "srli");
    drive(b(SRAI), 32'h8E5460F5, 32'h4, 0,
          32'hF8E5460F, "srai");
    drive(b(SLL), 32'h0E5460F5, 32'h4, 0,
          32'hE5460F50, "sll");
    drive(b(SRL), 32'h8E5460F5, 32'h4, 0,
          32'h08E5460F, "srl");
    drive(b(SRA), 32'h8E5460F5, 32'h4, 0,
          32'hF8E5460F, "sra");
    drive(b(SRA), 32'h8E5460F5, 32'h1F, 0,
          32'hFFFFFFFF, "sra_31");
    drive(b(ADD), 32'h09439AD4, 32'h00531794, 0,
          32'h0996B268, "add");
    drive(b(SUB), 32'h09439AD4, 32'h00531794, 0,
          32'h08F08340, "sub");
    drive(b(ADD), 32'hFFFFFFFF, 32'h2, 0,
          32'h00000001, "add_wrap");
    drive(b(XOR) | b(OR) | b(AND), 32'hF0F0F0F0,
          32'hFF00FF00, 0, 32'hF000F000, "and_prio");
    drive(b(ADD) | b(SW), 32'h100, 32'h5, 32'h20,
          32'h00000120, "sw_prio");
    drive('0, 32'h12345678, 32'h1, 32'h1,
          32'h0, "no_strobe");

    // Reset mid-operation, between edges.
    drive(b(ADD), 32'h11111111, 32'h22222222, 0,
          32'h33333333, "add_pre_rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async", result, 32'h0);
    st  = b(ADDI);
    rs1 = 32'h5;
    imm = 32'h5;
    @(posedge clk);
    #1;
    check("rst_hold", result, 32'h0);
    #2;
    rst_n = 1'b1;

    drive(b(BEQ), 32'hA5A5A5A5, 32'hA5A5A5A5, 0,
          32'h1, "beq");
    drive(b(BNE), 32'hA5A5A5A5, 32'hA5A5A5A5, 0,
          32'h0, "bne");
    drive(b(BLTU), 32'hFFFFFFFF, 32'h1, 0,
          32'h0, "bltu");
    drive(b(BLT), 32'hFFFFFFFF, 32'h1, 0,
          32'h1, "blt");
    drive(b(BGE), 32'hFFFFFFFF, 32'h1, 0,
          32'h0, "bge");
    drive(b(BGEU), 32'hFFFFFFFF, 32'h1, 0,
          32'h1, "bgeu");
    drive(b(BGE), 32'h7, 32'h7, 0,
          32'h1, "bge_eq");
    drive(b(LW), 32'h100, 0, 32'hFFFFFFFC,
          32'h000000FC, "lw");
    drive(b(LB), 32'h1000, 0, 32'h10,
          32'h00001010, "lb");
    drive(b(SB), 32'h80000000, 0, 32'h80000000,
          32'h0, "sb_wrap");

    @(negedge clk);
    st = '0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      failures++;
      checks++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
